// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package reg_wb_pkg;
    localparam int WB_AW = 5;
    localparam int WB_DW = 32;
    localparam logic [WB_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Result sources, decode read request, register-file write port and bypass query.
interface reg_wb_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          rd_req;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] count;
    logic          empty;
    logic [AW-1:0] q_addr;
    logic          q_hit;
    logic [DW-1:0] q_data;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rd_req, q_addr,
        input  alu_ready, mem_ready, wr, wr_addr, wr_data, count, empty, q_hit, q_data
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rd_req, q_addr,
        output alu_ready, mem_ready, wr, wr_addr, wr_data, count, empty, q_hit, q_data
    );
endinterface

// File: rtl/reg_wb_ctrl_fifo.sv
// In-order circular buffer of write-back entries; exposes entries oldest-first
// for the bypass search when REG_WB_BYPASS_EN is defined.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
`ifdef REG_WB_BYPASS_EN
    ,
    output wb_entry_t [DEPTH-1:0]    age_ents,
    output logic      [DEPTH-1:0]    age_vld
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wptr, rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign head = mem[rptr];

`ifdef REG_WB_BYPASS_EN
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign age_ents[k] = mem[rptr + PW'(k)];
        assign age_vld[k]  = CW'(k) < count;
    end
`endif
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back driver: arbitrates ALU/load results into a FIFO and
// drains them around decode reads. Optional bypass search: REG_WB_BYPASS_EN.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_wb_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic          not_full, mem_fire, alu_fire, push, pop;
    wb_entry_t     din, head;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
`ifdef REG_WB_BYPASS_EN
    wb_entry_t [DEPTH-1:0] age_ents;
    logic      [DEPTH-1:0] age_vld;
`endif

    // Readiness looks only at occupancy, never at a same-cycle pop.
    assign not_full      = count < CW'(DEPTH);
    assign bus.mem_ready = not_full;
    assign bus.alu_ready = not_full && !bus.mem_valid;
    assign mem_fire      = bus.mem_valid && not_full;
    assign alu_fire      = bus.alu_valid && not_full && !bus.mem_valid;

    always_comb begin
        din = mem_fire ? '{rd: bus.mem_rd, data: bus.mem_data}
                       : '{rd: bus.alu_rd, data: bus.alu_data};
    end

    // Writes to x0 complete the handshake but are dropped here.
    assign push = (mem_fire || alu_fire) && (din.rd != ZERO_REG);
    assign pop  = (count != '0) && !bus.rd_req;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (din),
        .pop      (pop),
        .head     (head),
        .count    (count)
`ifdef REG_WB_BYPASS_EN
        ,
        .age_ents (age_ents),
        .age_vld  (age_vld)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (pop) begin
            wr_q   <= 1'b1;
            addr_q <= head.rd;
            data_q <= head.data;
        end else begin
            wr_q   <= 1'b0;
        end
    end

    assign bus.wr      = wr_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign bus.count   = count;
    assign bus.empty   = (count == '0) && !wr_q;

`ifdef REG_WB_BYPASS_EN
    logic          hit;
    logic [DW-1:0] hit_data;

    // Scan oldest to newest so the last match (newest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        if (bus.q_addr != ZERO_REG) begin
            if (wr_q && addr_q == bus.q_addr) begin
                hit      = 1'b1;
                hit_data = data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (age_vld[k] && age_ents[k].rd == bus.q_addr) begin
                    hit      = 1'b1;
                    hit_data = age_ents[k].data;
                end
            end
        end
    end

    assign bus.q_hit  = hit;
    assign bus.q_data = hit_data;
`else
    assign bus.q_hit  = 1'b0;
    assign bus.q_data = '0;
`endif
endmodule
